// File: rtl/scan_demux4_pkg.sv
// Shared definitions for the parking-slot scanner: slot geometry, FSM encoding
// and the occupancy popcount helper.
package scan_demux4_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int COUNT_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [COUNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + COUNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/scan_demux4_debounce.sv
// Per-slot debouncer: the stable bit only flips after DEBOUNCE consecutive
// disagreeing samples; any agreeing sample clears the progress.
module slot_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic sample,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  // Reaching LAST means this disagreeing sample is the DEBOUNCE-th in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      if (sample == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sample;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_demux4.sv
// Sequential scanner for the 4:1 sensor mux: drives the select, samples W once
// per slot after a settling delay and keeps debounced per-slot occupancy.
module scan_demux4
  import scan_demux4_pkg::*;
#(
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 W,
  output logic [SLOT_W-1:0]    cont,
  output logic [NUM_SLOTS-1:0] ocup,
  output logic [COUNT_W-1:0]   livres,
  output logic                 cheio,
  output logic                 scan_done
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t        state, next_state;
  logic [SW-1:0] settle_cnt;
  logic          load;
  logic          start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping en anywhere in a scan abandons it without taking a sample.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = en ? S_SETTLE : S_IDLE;
      S_SETTLE: begin
        if (!en)                           next_state = S_IDLE;
        else if (settle_cnt == SETTLE_LAST) next_state = S_SAMPLE;
        else                               next_state = S_SETTLE;
      end
      S_SAMPLE: next_state = en ? S_SETTLE : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    load  = (state == S_SAMPLE) && en;
    start = (state == S_IDLE) && en;
  end

  // Select, settle counter and the end-of-scan pulse; a restart always begins at slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont       <= '0;
      settle_cnt <= '0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= load && (cont == SLOT_W'(NUM_SLOTS - 1));
      if (start) begin
        cont       <= '0;
        settle_cnt <= '0;
      end else if (load) begin
        cont       <= cont + 1'b1;
        settle_cnt <= '0;
      end else if (next_state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .load   (load && (cont == SLOT_W'(i))),
      .sample (W),
      .stable (ocup[i])
    );
  end

  always_comb begin
    livres = COUNT_W'(NUM_SLOTS) - popcount(ocup);
    cheio  = (livres == '0);
  end

endmodule

// File: tb/tb_scan_demux4.sv
// Directed bench for scan_demux4 at default parameters; the sensor mux is
// modelled by driving W from a per-slot pattern indexed by the select.
module tb_scan_demux4;

  logic       clk;
  logic       reset;
  logic       en;
  logic       w;
  logic [1:0] cont;
  logic [3:0] ocup;
  logic [2:0] livres;
  logic       cheio;
  logic       scan_done;

  logic [3:0] pat;
  logic [3:0] prev_ocup;
  int         checks;
  int         errors;
  int         n;

  scan_demux4 #(.SETTLE(2), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .W         (w),
    .cont      (cont),
    .ocup      (ocup),
    .livres    (livres),
    .cheio     (cheio),
    .scan_done (scan_done)
  );

  assign w = pat[cont];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] p);
    pat = p;
  endtask

  // Runs until the next scan_done pulse (bounded), remembering ocup one cycle earlier.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    do begin
      prev_ocup = ocup;
      tick();
      cycles++;
    end while (!scan_done && cycles < 40);
    checkOutput({tag, "_done"}, scan_done, 1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cont"}, cont, 0);
    checkOutput({tag, "_ocup"}, ocup, 0);
    checkOutput({tag, "_livres"}, livres, 4);
    checkOutput({tag, "_cheio"}, cheio, 0);
    checkOutput({tag, "_done"}, scan_done, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    en     = 1'b1;
    applyStimulus(4'b0000);

    tick();
    tick();
    checkReset("reset");
    reset = 1'b0;
    waitDone("first", n);
    checkOutput("first_latency", n, 13);
    checkOutput("first_ocup", ocup, 0);

    // Static pattern: slots 1 and 3 occupied.
    applyStimulus(4'b1010);
    waitDone("st1", n);
    checkOutput("scan_period", n, 12);
    checkOutput("st1_ocup", ocup, 0);
    waitDone("st2", n);
    checkOutput("st2_ocup", ocup, 0);
    waitDone("st3", n);
    checkOutput("st3_prev_ocup", prev_ocup, 4'b0010);
    checkOutput("st3_ocup", ocup, 4'b1010);
    checkOutput("st3_livres", livres, 2);
    checkOutput("st3_cheio", cheio, 0);
    tick();
    checkOutput("done_width", scan_done, 0);
    waitDone("st4", n);
    checkOutput("st4_gap", n, 11);
    checkOutput("st4_ocup", ocup, 4'b1010);

    // Glitch on slot 2: two scans then released, then three scans.
    applyStimulus(4'b1110);
    waitDone("gl1", n);
    waitDone("gl2", n);
    applyStimulus(4'b1010);
    waitDone("gl3", n);
    checkOutput("glitch_rejected", ocup, 4'b1010);
    applyStimulus(4'b1110);
    waitDone("gl4", n);
    waitDone("gl5", n);
    checkOutput("glitch_two_scans", ocup, 4'b1010);
    waitDone("gl6", n);
    checkOutput("glitch_accept_ocup", ocup, 4'b1110);
    checkOutput("glitch_accept_livres", livres, 1);

    // All slots occupied, then slot 0 freed.
    applyStimulus(4'b1111);
    waitDone("full1", n);
    waitDone("full2", n);
    checkOutput("full2_ocup", ocup, 4'b1110);
    waitDone("full3", n);
    checkOutput("full_ocup", ocup, 4'b1111);
    checkOutput("full_livres", livres, 0);
    checkOutput("full_cheio", cheio, 1);
    applyStimulus(4'b1110);
    waitDone("free1", n);
    waitDone("free2", n);
    checkOutput("free2_cheio", cheio, 1);
    waitDone("free3", n);
    checkOutput("free_ocup", ocup, 4'b1110);
    checkOutput("free_livres", livres, 1);
    checkOutput("free_cheio", cheio, 0);

    // Pause during slot 2 settle of the second scan; slot 0 progress must survive.
    applyStimulus(4'b1111);
    waitDone("pause1", n);
    repeat (7) tick();
    checkOutput("pause_at_slot2", cont, 2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("pause_cont", cont, 2);
      checkOutput("pause_done", scan_done, 0);
    end
    en = 1'b1;
    tick();
    checkOutput("resume_cont", cont, 0);
    tick();
    tick();
    checkOutput("resume_pre_ocup", ocup, 4'b1110);
    tick();
    checkOutput("resume_ocup", ocup, 4'b1111);
    checkOutput("resume_cheio", cheio, 1);
    waitDone("resume", n);
    checkOutput("resume_gap", n, 9);

    // Reset during SAMPLE of slot 1 with ocup=0110.
    applyStimulus(4'b0110);
    waitDone("mid1", n);
    waitDone("mid2", n);
    waitDone("mid3", n);
    checkOutput("mid_ocup", ocup, 4'b0110);
    checkOutput("mid_livres", livres, 2);
    applyStimulus(4'b1110);
    repeat (5) tick();
    checkOutput("mid_at_slot1", cont, 1);
    reset = 1'b1;
    tick();
    checkReset("midreset");
    reset = 1'b0;
    applyStimulus(4'b0001);
    waitDone("post1", n);
    checkOutput("post1_latency", n, 13);
    waitDone("post2", n);
    checkOutput("post2_ocup", ocup, 4'b0000);
    waitDone("post3", n);
    checkOutput("post3_ocup", ocup, 4'b0001);
    checkOutput("post3_livres", livres, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
